clock_display_driver: RTL

- Consumer of the seconds/minutes counter outputs: reads sec/min (binary, 0..59) and drives a 4-digit multiplexed 7-segment display as MM:SS.
- Snapshots the time once per scan frame so no frame shows a torn value, converts each field to BCD, scans digits round-robin with anti-ghost blanking, and blinks a colon at 1 Hz.

---
 rtl/clock_disp_pkg.sv | 19 +
 rtl/bcd_to_7seg.sv | 17 +
 rtl/clock_display_driver.sv | 130 +++++++++++++
 3 files changed

// File: rtl/clock_disp_pkg.sv
// Shared types and segment tables for the MM:SS multiplexed display driver.
package clock_disp_pkg;

  typedef enum logic [1:0] {
    DIG0,  // seconds ones
    DIG1,  // seconds tens
    DIG2,  // minutes ones
    DIG3   // minutes tens
  } digit_state_t;

  localparam logic [6:0] SEG_DASH = 7'h40;

  // Active-high gfedcba encodings for 0..9
  localparam logic [6:0] SEG_LUT [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-high gfedcba segments; invalid or >9 shows a dash.
module bcd_to_7seg
  import clock_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       invalid,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (!invalid && digit <= 4'd9) begin
      seg = SEG_LUT[digit];
    end
  end

endmodule

// File: rtl/clock_display_driver.sv
// Scans MM:SS onto a 4-digit multiplexed 7-segment display from a per-frame time snapshot.
// Outputs are registered (1-cycle latency); no backpressure, inputs are sampled once per frame.
module clock_display_driver
  import clock_disp_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int BLANK_CYC      = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int DW = $clog2(SCAN_DIV);

  logic [DW-1:0] div_cnt;
  logic          tick;
  digit_state_t  state, state_nxt;

  logic [5:0]    snap_sec, snap_min;
  logic          load_pending;

  logic [3:0]    sec_ones, sec_tens, min_ones, min_tens;
  logic          sec_bad, min_bad;
  logic [3:0]    dig_val;
  logic          dig_bad;
  logic [6:0]    seg_act;
  logic [3:0]    an_act;
  logic          dp_act;
  logic          show;

  // Slot prescaler
  assign tick = (div_cnt == DW'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= DIG0;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (tick) begin
      unique case (state)
        DIG0: state_nxt = DIG1;
        DIG1: state_nxt = DIG2;
        DIG2: state_nxt = DIG3;
        DIG3: state_nxt = DIG0;
      endcase
    end
  end

  // Reload at frame end so a frame never mixes two different times
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_sec     <= '0;
      snap_min     <= '0;
      load_pending <= 1'b1;
    end else begin
      load_pending <= 1'b0;
      if (load_pending || (state == DIG3 && tick)) begin
        snap_sec <= sec;
        snap_min <= min;
      end
    end
  end

  assign sec_ones = 4'(snap_sec % 6'd10);
  assign sec_tens = 4'(snap_sec / 6'd10);
  assign min_ones = 4'(snap_min % 6'd10);
  assign min_tens = 4'(snap_min / 6'd10);
  assign sec_bad  = (snap_sec > 6'd59);
  assign min_bad  = (snap_min > 6'd59);

  always_comb begin
    dig_val = sec_ones;
    dig_bad = sec_bad;
    an_act  = 4'b0001;
    unique case (state)
      DIG0: begin dig_val = sec_ones; dig_bad = sec_bad; an_act = 4'b0001; end
      DIG1: begin dig_val = sec_tens; dig_bad = sec_bad; an_act = 4'b0010; end
      DIG2: begin dig_val = min_ones; dig_bad = min_bad; an_act = 4'b0100; end
      DIG3: begin dig_val = min_tens; dig_bad = min_bad; an_act = 4'b1000; end
    endcase
    if (!show) begin
      an_act = 4'b0000;
    end
  end

  assign show   = (div_cnt >= DW'(BLANK_CYC));
  assign dp_act = show && (state == DIG2) && !snap_sec[0];

  bcd_to_7seg u_bcd (
    .digit   (dig_val),
    .invalid (dig_bad),
    .seg     (seg_act)
  );

  // Segments change during the blanked head of a slot, so no ghosting on the next digit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg <= {7{SEG_ACTIVE_LOW}};
      dp  <= SEG_ACTIVE_LOW;
      an  <= {4{AN_ACTIVE_LOW}};
    end else begin
      seg <= seg_act ^ {7{SEG_ACTIVE_LOW}};
      dp  <= dp_act ^ SEG_ACTIVE_LOW;
      an  <= an_act ^ {4{AN_ACTIVE_LOW}};
    end
  end

endmodule
